// File: rtl/serial_to_parallel_deser.sv
// rtl/serial_to_parallel_deser.sv - serial bit stream to DATA_WIDTH-bit words with one-entry valid/ready holding register
// Optional even-parity bit per word when PARITY_CHECK_EN is defined.
module serial_to_parallel_deser #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_bit_in,
  input  logic                  i_bit_valid,
  input  logic                  i_frame_start,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic                  o_overrun,
  output logic                  o_busy,
  output logic                  o_parity_err
);

  localparam int              CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [0:0]      S_COLLECT = 1'b0;
  localparam logic [0:0]      S_PARITY  = 1'b1;

  logic [DATA_WIDTH-1:0] r_sreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CW-1:0]         r_cnt;
  logic [0:0]            r_state;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_perr;

  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_last_data;
  logic                  w_done;
  logic                  w_word_perr;
  logic                  w_accept;
  logic                  w_load;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sreg[DATA_WIDTH-2:0], i_bit_in};
    end else begin : g_lsb
      assign w_shifted = {i_bit_in, r_sreg[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign w_last_data = i_bit_valid && (r_state == S_COLLECT) && (r_cnt == LAST_BIT);

`ifdef PARITY_CHECK_EN
  // The word was fully shifted in before the parity bit; a frame_start here aborts it.
  assign w_done      = i_bit_valid && (r_state == S_PARITY) && !i_frame_start;
  assign w_word      = r_sreg;
  assign w_word_perr = ^{r_sreg, i_bit_in};
`else
  assign w_done      = w_last_data;
  assign w_word      = w_shifted;
  assign w_word_perr = 1'b0;
`endif

  assign w_accept = r_valid & i_data_ready;
  assign w_load   = w_done & (~r_valid | w_accept);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_state <= S_COLLECT;
    end else if (i_bit_valid) begin
      if (r_state == S_PARITY) begin
        r_state <= S_COLLECT;
        if (i_frame_start) begin
          r_sreg <= w_shifted;
          r_cnt  <= CW'(1);
        end
      end else if (w_last_data) begin
        // frame_start on the completing bit is ignored: completion wins.
        r_sreg <= w_shifted;
        r_cnt  <= '0;
`ifdef PARITY_CHECK_EN
        r_state <= S_PARITY;
`endif
      end else if (i_frame_start) begin
        r_sreg <= w_shifted;
        r_cnt  <= CW'(1);
      end else begin
        r_sreg <= w_shifted;
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_overrun <= w_done & ~w_load;
      if (w_load) begin
        r_data  <= w_word;
        r_perr  <= w_word_perr;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;
  assign o_overrun    = r_overrun;
  assign o_parity_err = r_perr;
  assign o_busy       = (r_cnt != '0) || (r_state == S_PARITY);

endmodule

// File: tb/tb_serial_to_parallel_deser.sv
// tb/tb_serial_to_parallel_deser.sv - directed table and sequence bench for serial_to_parallel_deser
// Appends an even-parity bit per word when PARITY_CHECK_EN is defined.
module tb_serial_to_parallel_deser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bit_in;
  logic       bit_valid;
  logic       frame_start;
  logic       data_ready;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, ovr_m, ovr_l, busy_m, busy_l, perr_m, perr_l;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PARITY_CHECK_EN
  localparam logic PERR_EN = 1'b1;
`else
  localparam logic PERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_to_parallel_deser #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .i_clk(clk), .i_reset_n(reset_n), .i_bit_in(bit_in), .i_bit_valid(bit_valid),
    .i_frame_start(frame_start), .o_data_out(data_m), .o_data_valid(valid_m),
    .i_data_ready(data_ready), .o_overrun(ovr_m), .o_busy(busy_m), .o_parity_err(perr_m));

  serial_to_parallel_deser #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .i_clk(clk), .i_reset_n(reset_n), .i_bit_in(bit_in), .i_bit_valid(bit_valid),
    .i_frame_start(frame_start), .o_data_out(data_l), .o_data_valid(valid_l),
    .i_data_ready(data_ready), .o_overrun(ovr_l), .o_busy(busy_l), .o_parity_err(perr_l));

  typedef struct {
    logic [7:0] word;
    logic       lsb;
    logic       flip;
    logic       fs_last;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bit_in      = b;
    bit_valid   = 1'b1;
    frame_start = fs;
    step();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    bit_in      = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic lsb, input logic flip, input logic fs_last);
    for (int i = 0; i < 8; i++) send_bit(lsb ? w[i] : w[7-i], (i == 7) && fs_last);
`ifdef PARITY_CHECK_EN
    send_bit((^w) ^ flip, 1'b0);
`endif
  endtask

  initial begin
    reset_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; data_ready = 1'b1;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'h81};
    vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
    vecs[7] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12};

    step(); step();
    check("reset_valid", valid_m, 0);
    check("reset_data", data_m, 0);
    check("reset_overrun", ovr_m, 0);
    check("reset_busy", busy_m, 0);
    check("reset_perr", perr_m, 0);
    check("reset_valid_lsb", valid_l, 0);
    reset_n = 1'b1;
    step();

    // Back-to-back words with the consumer always ready.
    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].word, vecs[v].lsb, vecs[v].flip, vecs[v].fs_last);
      if (vecs[v].lsb) begin
        check($sformatf("vec%0d_valid", v), valid_l, 1);
        check($sformatf("vec%0d_data", v), data_l, vecs[v].exp_data);
        check($sformatf("vec%0d_perr", v), perr_l, vecs[v].flip & PERR_EN);
      end else begin
        check($sformatf("vec%0d_valid", v), valid_m, 1);
        check($sformatf("vec%0d_data", v), data_m, vecs[v].exp_data);
        check($sformatf("vec%0d_perr", v), perr_m, vecs[v].flip & PERR_EN);
      end
      step();
      check($sformatf("vec%0d_drained", v), vecs[v].lsb ? valid_l : valid_m, 0);
    end

    // Busy reflects a partial word.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    check("busy_partial", busy_m, 1);
    reset_n = 1'b0; #1; reset_n = 1'b1;
    step();

    // Holding register full: second word dropped with a one-cycle overrun.
    data_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ovr_first_valid", valid_m, 1);
    check("ovr_first_data", data_m, 8'h3C);
    check("ovr_no_flag_yet", ovr_m, 0);
    send_word(8'h81, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", ovr_m, 1);
    check("ovr_data_held", data_m, 8'h3C);
    check("ovr_valid_held", valid_m, 1);
    step();
    check("ovr_pulse_end", ovr_m, 0);
    check("ovr_data_still", data_m, 8'h3C);
    data_ready = 1'b1;
    step();
    check("ovr_accept", valid_m, 0);
    step(); step();
    check("ovr_no_second", valid_m, 0);

    // Gapped bit_valid with garbage on idle cycles.
    for (int i = 0; i < 8; i++) begin
      send_bit(8'hF0 >> (7 - i), 1'b0);
      bit_in = ~bit_in;
      if (i < 7) step();
    end
`ifdef PARITY_CHECK_EN
    step();
    send_bit(1'b0, 1'b0);
`endif
    check("gap_valid", valid_m, 1);
    check("gap_data", data_m, 8'hF0);
    step();
    check("gap_drained", valid_m, 0);

    // Junk bits, then frame_start realigns to a fresh word.
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_bit((8'h55 >> (7 - i)) & 8'h01, i == 0);
`ifdef PARITY_CHECK_EN
    send_bit(1'b0, 1'b0);
`endif
    check("fs_valid", valid_m, 1);
    check("fs_data", data_m, 8'h55);
    step(); step(); step();
    check("fs_single_word", valid_m, 0);
    check("fs_idle_busy", busy_m, 0);

    // Reset mid-word with a full holding register.
    data_ready = 1'b0;
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    check("rst_pre_valid", valid_m, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("rst_pre_busy", busy_m, 1);
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", valid_m, 0);
    check("rst_async_busy", busy_m, 0);
    check("rst_async_data", data_m, 0);
    step();
    check("rst_hold_valid", valid_m, 0);
    reset_n = 1'b1;
    data_ready = 1'b1;
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    check("rst_next_valid", valid_m, 1);
    check("rst_next_data", data_m, 8'h0F);
    step();
    check("rst_next_drained", valid_m, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
